// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select stage of a 4-state (K=3, 7/5 octal,
// rate 1/2) hard-decision Viterbi decoder. One received 2-bit symbol per
// cycle produces one registered 4-bit survivor decision vector, the best
// state and its metric, and frame bookkeeping for the traceback stage.
module viterbi_acs_unit #(
    parameter int unsigned PM_W       = 6,
    parameter int unsigned FRAME_SYMS = 8,
    parameter int unsigned INIT_PM    = 16
) (
    input  logic                          i_clk,
    input  logic                          rst_n,
    input  logic [1:0]                    i_sym,
    input  logic                          i_valid,
    input  logic                          i_last,
    output logic [3:0]                    o_dec,
    output logic                          o_dec_valid,
    output logic [$clog2(FRAME_SYMS)-1:0] o_step,
    output logic [1:0]                    o_best_state,
    output logic [PM_W-1:0]               o_best_pm,
    output logic                          o_frame_done,
    output logic                          o_err
);

    localparam int unsigned           STEP_W    = $clog2(FRAME_SYMS);
    localparam logic [PM_W-1:0]       INIT_V    = PM_W'(INIT_PM);
    localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(FRAME_SYMS - 1);

    // Hamming distance between the received symbol and the code bits
    // emitted when leaving state s with input bit u.
    function automatic logic [1:0] bmetric(input logic [1:0] sym,
                                           input logic [1:0] s,
                                           input logic       u);
        logic c0;
        logic c1;
        c0 = u ^ s[1] ^ s[0];
        c1 = u ^ s[0];
        return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
    endfunction

    logic [PM_W-1:0]   r_pm [4];
    logic [STEP_W-1:0] r_step;

    logic [PM_W-1:0]   w_pm_acs [4];
    logic [PM_W-1:0]   w_pm_new [4];
    logic [3:0]        w_dec;
    logic              w_norm;
    logic [1:0]        w_best_state;
    logic [PM_W-1:0]   w_best_pm;
    logic              w_at_last;
    logic              w_frame_end;
    logic              w_err_evt;

    // Next state ns={u,b} is reached from {b,0} or {b,1}; the odd
    // predecessor wins only when strictly better.
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        logic [PM_W-1:0] w_c0;
        logic [PM_W-1:0] w_c1;

        assign w_c0        = r_pm[P0] + PM_W'(bmetric(i_sym, P0, NS[1]));
        assign w_c1        = r_pm[P1] + PM_W'(bmetric(i_sym, P1, NS[1]));
        assign w_dec[g]    = (w_c1 < w_c0);
        assign w_pm_acs[g] = w_dec[g] ? w_c1 : w_c0;
    end

    // Drop the top metric bit from all states once every state has it set.
    always_comb begin
        w_norm = w_pm_acs[0][PM_W-1] & w_pm_acs[1][PM_W-1] &
                 w_pm_acs[2][PM_W-1] & w_pm_acs[3][PM_W-1];
        for (int unsigned i = 0; i < 4; i++) begin
            w_pm_new[i] = w_pm_acs[i];
            if (w_norm) begin
                w_pm_new[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Minimum new metric; ties keep the lowest state index.
    always_comb begin
        w_best_state = '0;
        w_best_pm    = w_pm_new[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (w_pm_new[i] < w_best_pm) begin
                w_best_pm    = w_pm_new[i];
                w_best_state = 2'(i);
            end
        end
    end

    // Frame terminates on i_last or on the final step position; a mismatch
    // between the two is an error but the frame still ends normally.
    always_comb begin
        w_at_last   = (r_step == LAST_STEP);
        w_frame_end = i_last | w_at_last;
        w_err_evt   = i_last ^ w_at_last;
    end

    // Metric/step state and registered outputs; idle cycles hold everything.
    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            r_pm         <= '{'0, INIT_V, INIT_V, INIT_V};
            r_step       <= '0;
            o_dec        <= '0;
            o_dec_valid  <= 1'b0;
            o_step       <= '0;
            o_best_state <= '0;
            o_best_pm    <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_dec_valid  <= i_valid;
            o_frame_done <= i_valid & w_frame_end;
            if (i_valid) begin
                o_dec        <= w_dec;
                o_step       <= r_step;
                o_best_state <= w_best_state;
                o_best_pm    <= w_best_pm;
                if (w_err_evt) begin
                    o_err <= 1'b1;
                end
                if (w_frame_end) begin
                    r_step <= '0;
                    r_pm   <= '{'0, INIT_V, INIT_V, INIT_V};
                end else begin
                    r_step <= r_step + 1'b1;
                    r_pm   <= w_pm_new;
                end
            end
        end
    end

endmodule

// File: doc/viterbi_acs_unit.md
# viterbi_acs_unit

Add-compare-select stage of the hard-decision Viterbi decoder. It consumes the 2-bit received code symbols that the PISO serializer emits one per cycle. It runs the 4-state (K=3, generators 7/5 octal, rate 1/2) trellis: it computes Hamming branch metrics, updates the path metrics and emits one 4-bit survivor decision vector per symbol to the survivor memory / traceback stage. It also reports the best end-of-frame state for traceback start.

## Interface
- PM_W, 6, path-metric width in bits (≥5)
- FRAME_SYMS, 8, symbols per frame (16-bit word / 2-bit symbol)
- INIT_PM, 16, initial metric for states 1..3 (state 0 starts at 0)

Ports:
- i_clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_sym  in  2  received symbol; i_sym[1]=c0 (g=111), i_sym[0]=c1 (g=101)
- i_valid  in  1  i_sym valid this cycle
- i_last  in  1  last symbol of frame; sampled only with i_valid
- o_dec  out  4  decision bits, o_dec[ns]=1 ⇒ survivor from predecessor {ns[0],1}
- o_dec_valid  out  1  o_dec valid, one pulse per accepted symbol
- o_step  out  $clog2(FRAME_SYMS)  trellis step index of o_dec (0-based in frame)
- o_best_state  out  2  state with minimum metric after this step
- o_best_pm  out  PM_W  that minimum metric
- o_frame_done  out  1  one-cycle pulse with the o_dec_valid of the last symbol
- o_err  out  1  sticky: FRAME_SYMS symbols seen without i_last, or i_last early

## Operation
- State s={u[t-1],u[t-2]}. Input u gives next state {u,s[1]}. Expected c0=u^s[1]^s[0], c1=u^s[0].
- Branch metric = Hamming distance(i_sym, {c0,c1}), range 0..2.
- For ns={u,b}: cand0=pm[{b,0}]+bm, cand1=pm[{b,1}]+bm. Pick cand1 only if strictly smaller; ties pick {b,0}, o_dec[ns]=0.
- Normalization: if bit PM_W-1 is set in all four new metrics, clear that bit in all four in the same update. Metric spread is ≤4, so overflow cannot occur.
- Best state: minimum new metric; ties resolve to the lowest state index.
- Step counter increments per accepted symbol. It clears to 0 after the last symbol, i.e. on i_last or on reaching FRAME_SYMS-1.
- Frame end: after the update on the last symbol, the metrics reload to {0,INIT_PM,INIT_PM,INIT_PM} for the next frame. The outputs of that cycle still show the pre-reload values.
- o_err sets if i_last arrives at step ≠ FRAME_SYMS-1, or if step FRAME_SYMS-1 passes without i_last. In both cases the frame is terminated as normal. o_err clears only on reset.
- No backpressure: every i_valid symbol is accepted. Idle cycles (i_valid=0) hold all state.

## Timing
- Latency 1 cycle: a symbol sampled at edge N gives o_dec/o_dec_valid/o_step/o_best_* registered at edge N, visible after it.
- Back-to-back symbols sustain 1 symbol/cycle.
- o_dec, o_step, o_best_state and o_best_pm hold their values while o_dec_valid=0.
- Reset values: o_dec=0, o_dec_valid=0, o_step=0, o_best_state=0, o_best_pm=0, o_frame_done=0, o_err=0. Metrics reset to {0,INIT_PM,INIT_PM,INIT_PM} and the step counter to 0.
- Reset mid-frame: the next edge with rst_n=0 discards the partial frame, and no o_frame_done is issued for it. rst_n dominates i_valid in the same cycle.

## Test plan
- All-zero frame: 8× sym 00, i_last on the 8th → o_dec_valid 8 pulses, o_step 0..7, o_best_state=0, o_best_pm=0 each step, o_frame_done with step 7, o_err=0.
- Encoded bits 1,0,1,1,0,0,0,0: syms 11,10,00,01,01,11,00,00 → final o_best_state=0, o_best_pm=0; step-0 o_best_state=2.
- Same frame with the first sym flipped to 01 → final o_best_state=0, o_best_pm=1.
- Two frames back-to-back with no gap, then a frame with i_valid gaps of 3 cycles → metrics reinit between frames and the outputs are identical to the gap-free case; no output changes during gaps.
- i_last at step 4, then a frame of 9 syms without i_last → o_err rises at step 4 and stays set; o_frame_done at step 4 and at step 7.
- rst_n low for 1 cycle after 3 syms, then a clean all-zero frame → all outputs 0 after reset; the following frame matches the first scenario.
